// File: rtl/enc_gray_arb.sv
// enc_gray_arb: round-robin arbiter sharing one binary-to-Gray converter among
// NREQ requesters. The result sits in a one-entry output register tagged with
// the winner's ID.
// Optional build macro ENC_GRAY_CHK_EN adds a Gray decoder, a shadow copy of
// the accepted binary word and a sticky err output.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | output register holds no word; any winner may load it
// ST_FULL  | output register holds a word; refill only when out_ready
module enc_gray_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 10,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [IDW-1:0]        out_id
`ifdef ENC_GRAY_CHK_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_ptr_nxt;
  logic             found;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] win_bin;
  logic [WIDTH-1:0] win_gray;
  logic             slot_free;
  logic             grant;

  assign out_valid = (state_q == ST_FULL);
  assign slot_free = (state_q == ST_EMPTY) || out_ready;
  assign grant     = found && slot_free && !rst;
  assign win_gray  = win_bin ^ (win_bin >> 1);

  // Round-robin search starting at rr_ptr; the index wraps explicitly at NREQ
  // so non-power-of-two requester counts never select a phantom requester.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_id  = '0;
    win_bin = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_id  = IDW'(idx);
        win_bin = req_bin[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the winner, and only when the slot can take a word.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;
  end

  // Pointer advances to the requester after the winner, wrapping at NREQ-1.
  always_comb begin
    rr_ptr_nxt = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
  end

  // Output register occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy: a grant always fills; a drain without refill empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (grant) state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Converted word, its ID and the priority pointer update only on a transfer;
  // on a plain drain the last word and ID stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_gray <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      out_gray <= win_gray;
      out_id   <= win_id;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

`ifdef ENC_GRAY_CHK_EN
  logic [WIDTH-1:0] shadow_bin;
  logic [WIDTH-1:0] dec_bin;

  // Shadow of the accepted binary word, loaded on the same edge as out_gray.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        shadow_bin <= '0;
    else if (grant) shadow_bin <= win_bin;
  end

  // Gray-to-binary decode: prefix XOR running down from the MSB.
  always_comb begin
    dec_bin = '0;
    dec_bin[WIDTH-1] = out_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ out_gray[i];
    end
  end

  // Sticky error on any decode mismatch while the output holds a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    err <= 1'b0;
    else if (out_valid && (dec_bin != shadow_bin)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_enc_gray_arb.sv
// Directed bench for enc_gray_arb: a 4-requester instance for the main
// scenarios plus a 3-requester instance to exercise the explicit pointer wrap.
module tb_enc_gray_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_bin;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_gray;
  logic [1:0]  out_id;

  logic [2:0]  req_valid3;
  logic [2:0]  req_ready3;
  logic [29:0] req_bin3;
  logic        out_valid3;
  logic        out_ready3;
  logic [9:0]  out_gray3;
  logic [1:0]  out_id3;

`ifdef ENC_GRAY_CHK_EN
  logic err;
  logic err3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] bin4  [4];
  logic [9:0] gray4 [4];
  logic [9:0] bin3  [3];
  logic [9:0] gray3 [3];

  always #5 clk = ~clk;

  enc_gray_arb #(.NREQ(4), .WIDTH(10), .IDW(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bin   (req_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_id    (out_id)
`ifdef ENC_GRAY_CHK_EN
    ,
    .err       (err)
`endif
  );

  enc_gray_arb #(.NREQ(3), .WIDTH(10), .IDW(2)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_bin   (req_bin3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_gray  (out_gray3),
    .out_id    (out_id3)
`ifdef ENC_GRAY_CHK_EN
    ,
    .err       (err3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bin4[0] = 10'h101; gray4[0] = 10'h181;
    bin4[1] = 10'h0F0; gray4[1] = 10'h088;
    bin4[2] = 10'h3C3; gray4[2] = 10'h222;
    bin4[3] = 10'h055; gray4[3] = 10'h07F;
    bin3[0] = 10'h200; gray3[0] = 10'h300;
    bin3[1] = 10'h001; gray3[1] = 10'h001;
    bin3[2] = 10'h3FF; gray3[2] = 10'h200;

    rst        = 1'b1;
    req_valid  = 4'hF;
    req_bin    = '0;
    out_ready  = 1'b0;
    req_valid3 = '0;
    req_bin3   = '0;
    out_ready3 = 1'b0;

    // Reset state, and no ready while reset is held even with requests up
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_gray",  32'(out_gray),  32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    step();
    rst       = 1'b0;
    req_valid = 4'h0;

    // Single request from requester 0
    req_valid     = 4'b0001;
    req_bin[9:0]  = 10'h3FF;
    out_ready     = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_gray",  32'(out_gray),  32'h200);
    chk("single_id",    32'(out_id),    32'd0);

    // Conversion values, back-to-back through requester 0
    req_bin[9:0] = 10'h000; step(); chk("conv_000", 32'(out_gray), 32'h000);
    req_bin[9:0] = 10'h2AA; step(); chk("conv_2AA", 32'(out_gray), 32'h3FF);
    req_bin[9:0] = 10'h155; step(); chk("conv_155", 32'(out_gray), 32'h1FF);
    req_bin[9:0] = 10'h004; step(); chk("conv_004", 32'(out_gray), 32'h006);
    chk("conv_valid", 32'(out_valid), 32'd1);

    // Drain with no new request: valid drops, word and ID hold
    req_valid = 4'b0000;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_gray",  32'(out_gray),  32'h006);
    chk("drain_id",    32'(out_id),    32'd0);

    // Round robin with all requesting; pointer sits at 1 after grants to 0
    for (int i = 0; i < 4; i++) req_bin[i*10 +: 10] = bin4[i];
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_id",    32'(out_id),    32'((k + 1) % 4));
      chk("rr_gray",  32'(out_gray),  32'(gray4[(k + 1) % 4]));
    end

    // Backpressure: held word from requester 0
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_id",    32'(out_id),    32'd0);
      chk("bp_gray",  32'(out_gray),  32'(gray4[0]));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    step();
    chk("bp_release_id",   32'(out_id),   32'd1);
    chk("bp_release_gray", 32'(out_gray), 32'(gray4[1]));

    // Asynchronous reset between edges while holding a word
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_gray",  32'(out_gray),  32'd0);
    chk("arst_id",    32'(out_id),    32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("arst_ptr0", 32'(req_ready), 32'b0001);
    req_valid = 4'b1000;
    #1;
    chk("arst_r3_ready", 32'(req_ready), 32'b1000);
    step();
    chk("arst_r3_id",   32'(out_id),   32'd3);
    chk("arst_r3_gray", 32'(out_gray), 32'(gray4[3]));
    req_valid = 4'h0;

    // Three requesters: pointer must wrap 2 -> 0
    for (int i = 0; i < 3; i++) req_bin3[i*10 +: 10] = bin3[i];
    req_valid3 = 3'b111;
    out_ready3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("wrap3_valid", 32'(out_valid3), 32'd1);
      chk("wrap3_id",    32'(out_id3),    32'(k % 3));
      chk("wrap3_gray",  32'(out_gray3),  32'(gray3[k % 3]));
    end
    req_valid3 = '0;

`ifdef ENC_GRAY_CHK_EN
    req_valid = 4'hF;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 4; i++) req_bin[i*10 +: 10] = 10'($urandom);
      step();
    end
    chk("chk_err_clean", 32'(err), 32'd0);
    req_valid = 4'h0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
